gate_sweep_checker: RTL
=======================

GATE_SWEEP_CHECKER -- requirements
Module: gate_sweep_checker

Interface
REQ-001 The block SHALL have parameter HOLD_CYCLES, default 4: the number of clock cycles each input vector is held before sampling. The legal range is 1..255.
REQ-002 The block SHALL have parameter EXPECT, default 4'b1000: the expected output of the gate under test, with bit i giving the expected value for vector {a,b}=i. The default is the AND truth table.
REQ-003 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 Port start, input, 1 bit: begins a sweep when sampled high in IDLE or DONE.
REQ-006 Port a, output, 1 bit: first input of the gate under test.
REQ-007 Port b, output, 1 bit: second input of the gate under test.
REQ-008 Port c, input, 1 bit: output of the gate under test.
REQ-009 Port busy, output, 1 bit: high while a sweep is in progress.
REQ-010 Port done, output, 1 bit: high from sweep completion until the next start or reset.
REQ-011 Port pass, output, 1 bit: valid while done is high; 1 means no mismatches were recorded.
REQ-012 Port err_count, output, 3 bits: number of mismatching vectors in the current or last sweep.
REQ-013 Port vec_idx, output, 2 bits: index of the vector currently applied.

Function
REQ-014 The FSM SHALL have the states IDLE, DRIVE, SAMPLE and DONE, all registered.
REQ-015 In IDLE or DONE, start=1 at a clock edge SHALL cause the following on that edge:
- move to DRIVE;
- set vec_idx to 0;
- clear err_count, done and pass;
- set busy to 1.
REQ-016 Outputs a and b SHALL be registered, with {a,b} equal to vec_idx whenever the FSM is in DRIVE or SAMPLE, and 0 in IDLE.
REQ-017 DRIVE SHALL last exactly HOLD_CYCLES cycles, counted by an 8-bit hold counter cleared on DRIVE entry. The FSM then moves to SAMPLE.
REQ-018 SAMPLE SHALL last exactly 1 cycle, with the following actions on its exit edge:
- compare c against EXPECT[vec_idx];
- increment err_count by 1 on mismatch.
REQ-019 On leaving SAMPLE with vec_idx<3, the FSM SHALL increment vec_idx and return to DRIVE. With vec_idx=3, it SHALL move to DONE.
REQ-020 On entering DONE, the block SHALL set done=1, busy=0, pass=(final err_count==0), and set {a,b} to 0. vec_idx SHALL hold at 3.
REQ-021 Start-to-done latency SHALL be exactly 4*(HOLD_CYCLES+1) cycles. With the default HOLD_CYCLES, done rises 20 edges after the start edge.
REQ-022 While busy=1, start SHALL be ignored, with no restart and no counter disturbance.
REQ-023 If start is still high in DONE, a new sweep SHALL begin on the next edge, per REQ-015.
REQ-024 err_count SHALL never exceed 4. No saturation logic is required, and no wrap SHALL occur.
REQ-025 Input c SHALL be used only in SAMPLE; its value in every other state SHALL be ignored.

Reset
REQ-026 While rst=1, regardless of clk, the block SHALL:
- go to IDLE;
- drive a, b, busy, done and pass to 0;
- clear err_count, vec_idx and the hold counter to 0.
REQ-027 An rst assertion mid-sweep SHALL abort the sweep immediately, with no done pulse. After rst deasserts, the block SHALL wait in IDLE for start.

Verification
REQ-028 Scenario: ideal AND gate on a/b/c, default parameters, 1-cycle start pulse.
- Stimulus: start pulse after reset.
- Required response: {a,b} = 00,01,10,11 with each vector present for 5 cycles; done=1 20 cycles after start; err_count=0; pass=1.
REQ-029 Scenario: c tied to 0.
- Stimulus: full sweep.
- Required response: err_count=1 (vector 11), pass=0, done=1.
REQ-030 Scenario: c tied to 1.
- Stimulus: full sweep.
- Required response: err_count=3 (vectors 00, 01, 10), pass=0.
REQ-031 Scenario: start re-pulsed while busy.
- Stimulus: second start pulse 8 cycles into a sweep.
- Required response: the pulse is ignored and done still rises at cycle 20. A subsequent start in DONE clears done/err_count and runs a new 20-cycle sweep.
REQ-032 Scenario: rst during a sweep.
- Stimulus: rst asserted asynchronously between clock edges at cycle 10.
- Required response: all outputs are 0 before the next edge, and the state is IDLE. A later start yields a complete, correct sweep.
REQ-033 Scenario: parameter override, HOLD_CYCLES=1 and EXPECT=4'b0110 (XOR), with an XOR gate connected.
- Stimulus: full sweep.
- Required response: done at 8 cycles after start, pass=1.

Source files
------------

// File: rtl/gate_sweep_checker.sv
// Exhaustive two-input gate tester: applies {a,b}=0..3, holds each vector for
// HOLD_CYCLES, samples the gate output c once per vector and counts mismatches.
module gate_sweep_checker #(
  parameter int         HOLD_CYCLES = 4,
  parameter logic [3:0] EXPECT      = 4'b1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       a,
  output logic       b,
  input  logic       c,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [1:0] vec_idx
);

  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

  state_t     state_q, state_d;
  logic [7:0] hold_q, hold_d;
  logic [2:0] err_q, err_d;
  logic [1:0] vec_q, vec_d;
  logic       a_q, a_d;
  logic       b_q, b_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;
  logic       mismatch;

  // c only matters on the single SAMPLE cycle; everywhere else it is ignored.
  assign mismatch = (state_q == SAMPLE) && (c != EXPECT[vec_q]);

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    err_d   = err_q;
    vec_d   = vec_q;
    a_d     = a_q;
    b_d     = b_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = DRIVE;
          hold_d  = 8'd0;
          err_d   = 3'd0;
          vec_d   = 2'd0;
          a_d     = 1'b0;
          b_d     = 1'b0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          pass_d  = 1'b0;
        end
      end
      DRIVE: begin
        if (hold_q == HOLD_LAST) begin
          state_d = SAMPLE;
        end else begin
          hold_d = hold_q + 8'd1;
        end
      end
      SAMPLE: begin
        err_d = err_q + 3'(mismatch);
        if (vec_q == 2'd3) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_d == 3'd0);
          a_d     = 1'b0;
          b_d     = 1'b0;
        end else begin
          state_d      = DRIVE;
          hold_d       = 8'd0;
          vec_d        = vec_q + 2'd1;
          {a_d, b_d}   = vec_q + 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      hold_q  <= 8'd0;
      err_q   <= 3'd0;
      vec_q   <= 2'd0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      err_q   <= err_d;
      vec_q   <= vec_d;
      a_q     <= a_d;
      b_q     <= b_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  assign a         = a_q;
  assign b         = b_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;
  assign vec_idx   = vec_q;

endmodule
